// File: rtl/fetch_stage.sv
// Purpose: instruction fetch stage with a PC register, IMEM request handshake and IF/ID register.
// Latency: a completed fetch reaches IF/ID one cycle later; a redirect is fetched from one cycle later (or one cycle after the drain ends).
// Backpressure: a request stays asserted at a stable address until imemReady__i; a stall parks one completed fetch in a hold buffer and drops the request.
//
// Ports:
//   clock__i, reset_n__i         clock, synchronous active-low reset
//   stall__i                     hazard stall, freezes IF/ID
//   branch__i, equal__i,         taken BEQ when both are high
//   branchTarget__i
//   jump__i, jumpTarget__i       unconditional jump, wins over a branch
//   imemReady__i, imemData__i    instruction memory response
//   imemReq__o, imemAddr__o      instruction memory request
//   instr__o, pcPlus4__o,        IF/ID register
//   valid__o
module fetch_stage #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clock__i,
    input  logic             reset_n__i,
    input  logic             stall__i,
    input  logic             branch__i,
    input  logic             equal__i,
    input  logic [WIDTH-1:0] branchTarget__i,
    input  logic             jump__i,
    input  logic [WIDTH-1:0] jumpTarget__i,
    input  logic             imemReady__i,
    input  logic [WIDTH-1:0] imemData__i,
    output logic             imemReq__o,
    output logic [WIDTH-1:0] imemAddr__o,
    output logic [WIDTH-1:0] instr__o,
    output logic [WIDTH-1:0] pcPlus4__o,
    output logic             valid__o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] hold_instr, hold_instr_nxt;
    logic [WIDTH-1:0] hold_pc4, hold_pc4_nxt;
    logic [WIDTH-1:0] drain_tgt, drain_tgt_nxt;
    logic [WIDTH-1:0] instr_nxt, pc4_nxt;
    logic             valid_nxt;

    logic             redirect;
    logic [WIDTH-1:0] redirect_tgt;
    logic [WIDTH-1:0] pc_inc;
    logic             done;

    // Jump wins over a taken branch.
    assign redirect     = jump__i | (branch__i & equal__i);
    assign redirect_tgt = jump__i ? jumpTarget__i : branchTarget__i;
    assign pc_inc       = pc + FOUR;

    // Request is gated by reset so nothing is issued while reset is held.
    assign imemReq__o   = reset_n__i & (state != HOLD);
    assign imemAddr__o  = pc;
    assign done         = imemReq__o & imemReady__i;

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        hold_instr_nxt = hold_instr;
        hold_pc4_nxt   = hold_pc4;
        drain_tgt_nxt  = drain_tgt;
        instr_nxt      = instr__o;
        pc4_nxt        = pcPlus4__o;
        valid_nxt      = valid__o;

        unique case (state)
            FETCH: begin
                if (done) begin
                    if (redirect) begin
                        pc_nxt    = redirect_tgt;
                        valid_nxt = 1'b0;
                    end else if (stall__i) begin
                        // IF/ID is frozen, so park the word until the stall lifts.
                        hold_instr_nxt = imemData__i;
                        hold_pc4_nxt   = pc_inc;
                        pc_nxt         = pc_inc;
                        state_nxt      = HOLD;
                    end else begin
                        instr_nxt = imemData__i;
                        pc4_nxt   = pc_inc;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_inc;
                    end
                end else if (redirect) begin
                    // The address must stay stable until the memory answers,
                    // so remember the target and finish the stale fetch first.
                    drain_tgt_nxt = redirect_tgt;
                    valid_nxt     = 1'b0;
                    state_nxt     = DRAIN;
                end else if (!stall__i) begin
                    valid_nxt = 1'b0;
                end
            end

            DRAIN: begin
                valid_nxt = 1'b0;
                if (redirect) begin
                    drain_tgt_nxt = redirect_tgt;
                end
                if (done) begin
                    // A redirect arriving on the completing cycle is the newest one.
                    pc_nxt    = redirect ? redirect_tgt : drain_tgt;
                    state_nxt = FETCH;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nxt    = redirect_tgt;
                    valid_nxt = 1'b0;
                    state_nxt = FETCH;
                end else if (!stall__i) begin
                    instr_nxt = hold_instr;
                    pc4_nxt   = hold_pc4;
                    valid_nxt = 1'b1;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock__i) begin
        if (!reset_n__i) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            hold_instr <= '0;
            hold_pc4   <= '0;
            drain_tgt  <= '0;
            instr__o   <= '0;
            pcPlus4__o <= '0;
            valid__o   <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            hold_instr <= hold_instr_nxt;
            hold_pc4   <= hold_pc4_nxt;
            drain_tgt  <= drain_tgt_nxt;
            instr__o   <= instr_nxt;
            pcPlus4__o <= pc4_nxt;
            valid__o   <= valid_nxt;
        end
    end

endmodule
